ram_indirect_ctrl: RTL

- Parametrised single-port synchronous RAM with a valid/ready request channel and a held response channel.
- Supports direct and indirect (pointer-chasing) reads and writes, sequenced by a small FSM.
- Adds range checking against a configurable depth.
- Sits between the CPU datapath and on-chip data memory.
- Replaces the tri-state cs/we/oe RAM with a clocked, handshaked interface.

---
 rtl/ram_indirect_ctrl_if.sv | 26 ++
 rtl/ram_indirect_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ram_indirect_ctrl_if.sv
// Request/response channel between a requester (master) and ram_indirect_ctrl (slave).
interface ram_indirect_ctrl_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_ind;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_ind, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_ind, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_indirect_ctrl.sv
// Single-port RAM with direct/indirect (pointer-chasing) access, range checking and a held response.
// Optional macro PARITY_EN adds a per-word even-parity bit and the par_inject test input.
module ram_indirect_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 1 << ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PARITY_EN
    input  logic               par_inject,
`endif
    ram_indirect_ctrl_if.slave bus
);

    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int PTR_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(LENGTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PTR,
        S_ACC,
        S_RESP
    } state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    // A stored word becomes a pointer: keep its low address bits, zero-extend short words.
    function automatic logic [ADDR_WIDTH-1:0] ptr_of(input logic [DATA_WIDTH-1:0] w);
        logic [PTR_W-1:0] wide;
        wide = PTR_W'(w);
        return wide[ADDR_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:LENGTH-1];
`ifdef PARITY_EN
    logic                  mem_par [0:LENGTH-1];
    logic                  r_par_inject;
`endif

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_we;
    logic                  r_ind;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  r_abort;

    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_target_ok;
    logic [DATA_WIDTH-1:0] w_ptr_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_ptr_par_bad;
    logic                  w_rd_par_bad;
    logic                  w_mem_we;

    assign w_target    = r_ind ? r_target : r_addr;
    assign w_target_ok = in_range(w_target);
    assign w_ptr_word  = mem[idx(r_addr)];
    assign w_rd_word   = mem[idx(w_target)];

`ifdef PARITY_EN
    assign w_ptr_par_bad = (^w_ptr_word) != mem_par[idx(r_addr)];
    assign w_rd_par_bad  = (^w_rd_word) != mem_par[idx(w_target)];
`else
    assign w_ptr_par_bad = 1'b0;
    assign w_rd_par_bad  = 1'b0;
`endif

    // An async reset drops r_state to IDLE at once, so a pending write can never commit.
    assign w_mem_we = (r_state == S_ACC) && r_we && w_target_ok && !r_abort;

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // NOTE: the storage array has no reset branch; its contents survive rst_n and a
    // reset would otherwise stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[idx(w_target)] <= r_wdata;
`ifdef PARITY_EN
            mem_par[idx(w_target)] <= (^r_wdata) ^ r_par_inject;
`endif
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples the
    // pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_ind       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_target    <= '0;
            r_abort     <= 1'b0;
`ifdef PARITY_EN
            r_par_inject <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_we        <= bus.req_we;
                        r_ind       <= bus.req_ind;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_abort     <= 1'b0;
                        r_req_ready <= 1'b0;
`ifdef PARITY_EN
                        r_par_inject <= par_inject;
`endif
                        if (!in_range(bus.req_addr)) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= bus.req_ind ? S_PTR : S_ACC;
                        end
                    end
                end

                S_PTR: begin
                    r_target <= ptr_of(w_ptr_word);
                    r_abort  <= w_ptr_par_bad;
                    r_state  <= S_ACC;
                end

                S_ACC: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    if (!w_target_ok || r_abort) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else if (r_we) begin
                        r_rsp_rdata <= r_wdata;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_rsp_rdata <= w_rd_word;
                        r_rsp_err   <= w_rd_par_bad;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
